vend_sequencer: RTL and testbench

//  Transaction sequencer for the drink vending datapath.
//  - Accumulates coin credit and checks the selected item's price.
//  - Hands the item request to the dispenser over a req/ack handshake.
//  - Pays change back one coin at a time over a second req/ack handshake.
//  - Sits between the coin/button front end and the dispenser + change hopper; drives the panel indicators.

---
 rtl/vend_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_vend_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// Drink vending transaction sequencer.
// Accumulates coin credit, checks the selected item's price, hands the item
// to the dispenser over a req/ack handshake, then pays change back one coin
// at a time over a second req/ack handshake to the change hopper.
module vend_sequencer #(
    parameter int CW       = 8,
    parameter int PRICE0   = 5,
    parameter int PRICE1   = 10,
    parameter int PRICE2   = 15,
    parameter int PRICE3   = 20,
    parameter int BIG_COIN = 5,
    parameter int IDLE_TO  = 1000,
    parameter int HOLD_CYC = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          coin_valid,
    input  logic [2:0]    coin_val,
    input  logic          sel_valid,
    input  logic [1:0]    sel_item,
    input  logic          cancel,
    input  logic          disp_ack,
    input  logic          chg_ack,
    output logic          disp_req,
    output logic [1:0]    disp_item,
    output logic          chg_req,
    output logic [2:0]    chg_coin,
    output logic          coin_rej,
    output logic          insuf,
    output logic [CW-1:0] credit,
    output logic          done_ind,
    output logic          busy,
    output logic [2:0]    state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CREDIT = 3'd1;
    localparam logic [2:0] S_VEND   = 3'd2;
    localparam logic [2:0] S_CHANGE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // Counter widths sized so each counter can hold its terminal value.
    localparam int TW = $clog2(IDLE_TO + 1);
    localparam int HW = $clog2(HOLD_CYC + 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [1:0]    disp_item_q, disp_item_d;
    logic          disp_req_q, disp_req_d;
    logic          chg_req_q, chg_req_d;
    logic [2:0]    chg_coin_q, chg_coin_d;
    logic          coin_rej_q, coin_rej_d;
    logic          insuf_q, insuf_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [HW-1:0] hold_q, hold_d;

    logic [CW:0]   coin_sum;
    logic          coin_fits;
    logic [CW-1:0] sel_price;
    logic          sel_ok;
    logic          cr_quiet;
    logic          timeout;
    logic          hold_last;
    logic [2:0]    chg_due;

    function automatic logic [CW-1:0] price_of(input logic [1:0] item);
        case (item)
            2'd0:    price_of = CW'(PRICE0);
            2'd1:    price_of = CW'(PRICE1);
            2'd2:    price_of = CW'(PRICE2);
            default: price_of = CW'(PRICE3);
        endcase
    endfunction

    // Shared decode: coin overflow, price check, idle timeout, hold end, next change coin.
    always_comb begin
        coin_sum  = (CW+1)'(credit_q) + (CW+1)'(coin_val);
        coin_fits = ~coin_sum[CW];
        sel_price = price_of(sel_item);
        sel_ok    = (credit_q >= sel_price);
        // A quiet CREDIT cycle is one with no cancel, no select and no accepted coin;
        // a coin rejected for overflow does not restart the timer.
        cr_quiet  = !cancel && !sel_valid && !(coin_valid && coin_fits);
        timeout   = cr_quiet && (timer_q == TW'(IDLE_TO - 1));
        hold_last = (hold_q == HW'(HOLD_CYC - 1));
        chg_due   = (credit_q >= CW'(BIG_COIN)) ? 3'(BIG_COIN) : 3'd1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (coin_valid && (coin_val != 3'd0)) state_d = S_CREDIT;
            end
            S_CREDIT: begin
                if (cancel)                 state_d = S_CHANGE;
                else if (sel_valid && sel_ok) state_d = S_VEND;
                else if (timeout)           state_d = S_CHANGE;
            end
            S_VEND: begin
                if (disp_ack && disp_req_q) state_d = S_CHANGE;
            end
            S_CHANGE: begin
                if (!chg_req_q && (credit_q == '0)) state_d = S_DONE;
            end
            S_DONE: begin
                if (hold_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: credit, handshake requests, pulses, timers.
    always_comb begin
        credit_d    = credit_q;
        disp_item_d = disp_item_q;
        disp_req_d  = disp_req_q;
        chg_req_d   = chg_req_q;
        chg_coin_d  = chg_coin_q;
        coin_rej_d  = 1'b0;
        insuf_d     = 1'b0;
        timer_d     = (state_q == S_CREDIT && cr_quiet) ? timer_q + TW'(1) : '0;
        hold_d      = (state_q == S_DONE) ? hold_q + HW'(1) : '0;
        case (state_q)
            S_IDLE: begin
                if (coin_valid && (coin_val != 3'd0)) credit_d = CW'(coin_val);
            end
            S_CREDIT: begin
                coin_rej_d = coin_valid && (cancel || sel_valid || !coin_fits);
                if (!cancel) begin
                    if (sel_valid) begin
                        if (sel_ok) begin
                            credit_d    = credit_q - sel_price;
                            disp_item_d = sel_item;
                            disp_req_d  = 1'b1;
                        end else begin
                            insuf_d = 1'b1;
                        end
                    end else if (coin_valid && coin_fits) begin
                        credit_d = coin_sum[CW-1:0];
                    end
                end
            end
            S_VEND: begin
                coin_rej_d = coin_valid;
                if (disp_ack && disp_req_q) disp_req_d = 1'b0;
            end
            S_CHANGE: begin
                coin_rej_d = coin_valid;
                if (chg_req_q) begin
                    // Dropping the request after each ack guarantees a low cycle between coins.
                    if (chg_ack) begin
                        credit_d  = credit_q - CW'(chg_coin_q);
                        chg_req_d = 1'b0;
                    end
                end else if (credit_q != '0) begin
                    chg_req_d  = 1'b1;
                    chg_coin_d = chg_due;
                end
            end
            S_DONE: begin
                coin_rej_d = coin_valid;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q    <= '0;
            disp_item_q <= '0;
            disp_req_q  <= 1'b0;
            chg_req_q   <= 1'b0;
            chg_coin_q  <= '0;
            coin_rej_q  <= 1'b0;
            insuf_q     <= 1'b0;
            timer_q     <= '0;
            hold_q      <= '0;
        end else begin
            credit_q    <= credit_d;
            disp_item_q <= disp_item_d;
            disp_req_q  <= disp_req_d;
            chg_req_q   <= chg_req_d;
            chg_coin_q  <= chg_coin_d;
            coin_rej_q  <= coin_rej_d;
            insuf_q     <= insuf_d;
            timer_q     <= timer_d;
            hold_q      <= hold_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        disp_req  = disp_req_q;
        disp_item = disp_item_q;
        chg_req   = chg_req_q;
        chg_coin  = chg_coin_q;
        coin_rej  = coin_rej_q;
        insuf     = insuf_q;
        credit    = credit_q;
        done_ind  = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        state     = state_q;
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: directed stimulus, a cycle model of the vending
// rules compared every cycle, plus hand-computed literal expectations.
module tb_vend_sequencer;

    localparam int CW      = 8;
    localparam int IDLE_TO = 20;
    localparam int HOLD    = 5;
    localparam int BIG     = 5;

    int price[4] = '{5, 10, 15, 20};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          coin_valid = 1'b0;
    logic [2:0]    coin_val = 3'd0;
    logic          sel_valid = 1'b0;
    logic [1:0]    sel_item = 2'd0;
    logic          cancel = 1'b0;
    logic          disp_ack;
    logic          chg_ack;
    logic          disp_req;
    logic [1:0]    disp_item;
    logic          chg_req;
    logic [2:0]    chg_coin;
    logic          coin_rej;
    logic          insuf;
    logic [CW-1:0] credit;
    logic          done_ind;
    logic          busy;
    logic [2:0]    state;

    vend_sequencer #(
        .CW(CW), .PRICE0(5), .PRICE1(10), .PRICE2(15), .PRICE3(20),
        .BIG_COIN(BIG), .IDLE_TO(IDLE_TO), .HOLD_CYC(HOLD)
    ) dut (
        .clk(clk), .reset(reset),
        .coin_valid(coin_valid), .coin_val(coin_val),
        .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
        .disp_ack(disp_ack), .chg_ack(chg_ack),
        .disp_req(disp_req), .disp_item(disp_item),
        .chg_req(chg_req), .chg_coin(chg_coin),
        .coin_rej(coin_rej), .insuf(insuf), .credit(credit),
        .done_ind(done_ind), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // States: 0 idle, 1 collecting credit, 2 dispensing, 3 paying change, 4 done.
    int m_st = 0, m_cr = 0, m_item = 0, m_quiet = 0, m_left = 0, m_ccoin = 0;
    bit m_dreq = 0, m_creq = 0, m_rej = 0, m_ins = 0;

    task automatic model_step();
        bit rej = 0, ins = 0;
        if (reset) begin
            m_st = 0; m_cr = 0; m_item = 0; m_quiet = 0; m_left = 0; m_ccoin = 0;
            m_dreq = 0; m_creq = 0; m_rej = 0; m_ins = 0;
            return;
        end
        case (m_st)
            0: if (coin_valid && coin_val != 0) begin
                   m_cr = coin_val; m_quiet = 0; m_st = 1;
               end
            1: begin
                if (cancel) begin
                    rej = coin_valid; m_st = 3;
                end else if (sel_valid) begin
                    rej = coin_valid; m_quiet = 0;
                    if (m_cr >= price[sel_item]) begin
                        m_cr = m_cr - price[sel_item]; m_item = sel_item; m_dreq = 1; m_st = 2;
                    end else ins = 1;
                end else if (coin_valid && (m_cr + coin_val <= (1 << CW) - 1)) begin
                    m_cr = m_cr + coin_val; m_quiet = 0;
                end else begin
                    rej = coin_valid;
                    m_quiet++;
                    if (m_quiet == IDLE_TO) m_st = 3;
                end
            end
            2: begin
                rej = coin_valid;
                if (disp_ack && m_dreq) begin m_dreq = 0; m_st = 3; end
            end
            3: begin
                rej = coin_valid;
                if (m_creq) begin
                    if (chg_ack) begin m_cr = m_cr - m_ccoin; m_creq = 0; end
                end else if (m_cr == 0) begin
                    m_st = 4; m_left = HOLD;
                end else begin
                    m_creq = 1; m_ccoin = (m_cr >= BIG) ? BIG : 1;
                end
            end
            default: begin
                rej = coin_valid;
                m_left--;
                if (m_left == 0) m_st = 0;
            end
        endcase
        m_rej = rej; m_ins = ins;
    endtask

    // Compare on the falling edge, then advance the model with the inputs
    // the DUT will sample at the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("state", state, m_st);
            chk("credit", credit, m_cr);
            chk("disp_req", disp_req, m_dreq);
            chk("chg_req", chg_req, m_creq);
            chk("coin_rej", coin_rej, m_rej);
            chk("insuf", insuf, m_ins);
            chk("done_ind", done_ind, (m_st == 4));
            chk("busy", busy, (m_st != 0));
            if (m_dreq) chk("disp_item", disp_item, m_item);
            if (m_creq) chk("chg_coin", chg_coin, m_ccoin);
            model_step();
        end
    end

    // ---------------- dispenser / hopper responders ----------------
    bit disp_en = 1, chg_en = 1;
    int coins_q[$];

    initial begin
        int dcnt = 0, ccnt = 0;
        disp_ack = 1'b0;
        chg_ack  = 1'b0;
        forever begin
            @(posedge clk); #1;
            disp_ack = 1'b0;
            chg_ack  = 1'b0;
            if (disp_en && disp_req) begin
                if (dcnt == 1) begin disp_ack = 1'b1; dcnt = 0; end
                else dcnt++;
            end else dcnt = 0;
            if (chg_en && chg_req) begin
                if (ccnt == 1) begin chg_ack = 1'b1; ccnt = 0; coins_q.push_back(int'(chg_coin)); end
                else ccnt++;
            end else ccnt = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic put_coin(input int v);
        coin_valid = 1'b1; coin_val = 3'(v);
        tick();
        coin_valid = 1'b0; coin_val = 3'd0;
    endtask

    task automatic press(input int item);
        sel_valid = 1'b1; sel_item = 2'(item);
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic wait_state(input string name, input int s, input int budget);
        int n = 0;
        while (int'(state) != s && n < budget) begin tick(); n++; end
        n_vec++;
        if (int'(state) != s) begin
            n_bad++;
            $display("FAIL %s: timeout, state %0d, expected %0d", name, state, s);
        end
    endtask

    task automatic chk_coins(input string name, input int exp[$]);
        chk({name, " count"}, coins_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < coins_q.size(); i++)
            chk({name, " coin"}, coins_q[i], exp[i]);
        coins_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int n;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset state", state, 0);
        chk("reset credit", credit, 0);

        // 1: 5+5, buy item 1 at 10 -> no change, DONE for HOLD cycles
        coins_q.delete();
        put_coin(5); put_coin(5);
        press(1);
        chk("t1 vend", state, 2);
        chk("t1 item", disp_item, 1);
        chk("t1 credit", credit, 0);
        wait_state("t1 to done", 4, 40);
        n = 0;
        while (state == 3'd4 && n < 20) begin n++; tick(); end
        chk("t1 done cycles", n, 5);
        chk("t1 idle", state, 0);
        chk_coins("t1", '{});

        // 2: 5+5+5+2 = 17, item 0 at 5 -> 12 change = 5,5,1,1
        put_coin(5); put_coin(5); put_coin(5); put_coin(2);
        chk("t2 credit", credit, 17);
        press(0);
        chk("t2 credit after", credit, 12);
        wait_state("t2 idle", 0, 200);
        chk_coins("t2", '{5, 5, 1, 1});
        chk("t2 credit end", credit, 0);

        // 3: insufficient credit, then cancel refunds one 5
        put_coin(5);
        press(3);
        chk("t3 insuf", insuf, 1);
        chk("t3 credit", credit, 5);
        chk("t3 state", state, 1);
        do_cancel();
        wait_state("t3 idle", 0, 100);
        chk_coins("t3", '{5});

        // 4: cancel + sel + coin together
        put_coin(5);
        cancel = 1'b1; sel_valid = 1'b1; sel_item = 2'd0; coin_valid = 1'b1; coin_val = 3'd4;
        tick();
        cancel = 1'b0; sel_valid = 1'b0; coin_valid = 1'b0; coin_val = 3'd0;
        chk("t4 state", state, 3);
        chk("t4 coin_rej", coin_rej, 1);
        chk("t4 credit", credit, 5);
        wait_state("t4 idle", 0, 100);
        chk_coins("t4", '{5});

        // 5: idle timeout returns 3 as three 1-coins
        put_coin(3);
        n = 0;
        while (state == 3'd1 && n < IDLE_TO + 10) begin n++; tick(); end
        chk("t5 credit cycles", n, IDLE_TO);
        chk("t5 change", state, 3);
        wait_state("t5 idle", 0, 100);
        chk_coins("t5", '{1, 1, 1});

        // overflow: 36*7 = 252, +4 rejected, +3 reaches 255
        for (int i = 0; i < 36; i++) put_coin(7);
        put_coin(4);
        chk("ovf rej", coin_rej, 1);
        chk("ovf credit", credit, 252);
        put_coin(3);
        chk("ovf credit max", credit, 255);
        do_cancel();
        wait_state("ovf idle", 0, 1000);
        chk("ovf ncoins", coins_q.size(), 51);
        coins_q.delete();

        // 6: reset mid-CHANGE with credit 7, then coin during VEND
        chg_en = 0;
        put_coin(5); put_coin(2);
        do_cancel();
        tick(); tick();
        chk("t6 chg_req", chg_req, 1);
        chk("t6 chg_coin", chg_coin, 5);
        chk("t6 credit", credit, 7);
        reset = 1'b1;
        tick();
        chk("t6 rst state", state, 0);
        chk("t6 rst credit", credit, 0);
        chk("t6 rst chg_req", chg_req, 0);
        reset = 1'b0;
        chg_en = 1;
        disp_en = 0;
        put_coin(5); put_coin(5);
        press(1);
        put_coin(1);
        chk("t6 vend rej", coin_rej, 1);
        chk("t6 vend state", state, 2);
        tick();
        chk("t6 rej pulse", coin_rej, 0);
        disp_en = 1;
        wait_state("t6 idle", 0, 100);
        chk_coins("t6", '{});

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
